// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared widths, frame constants, SPI command codes and FSM states
package shared_pkg;

  localparam int MEM_WIDTH  = 8;
  localparam int FRAME_BITS = 10;
  localparam int TX_TIMEOUT = 16;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_tx_serializer.sv
// rtl/spi_tx_serializer.sv - loads one RAM word and shifts it out MSB-first
// bit_o is the current bit while busy_o is high; done_o marks the last bit.
module spi_tx_serializer
  import shared_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [MEM_WIDTH-1:0] data_i,
  output logic                 bit_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CW = $clog2(MEM_WIDTH + 1);

  logic [MEM_WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (load_i) begin
      sh_d  = data_i;
      cnt_d = CW'(MEM_WIDTH);
    end else if (cnt_q != '0) begin
      sh_d  = {sh_q[MEM_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign bit_o  = busy_o & sh_q[MEM_WIDTH-1];
  assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/spi_slave_frontend.sv
// rtl/spi_slave_frontend.sv - SPI slave frame FSM feeding the RAM and returning read data on MISO
// Optional macro SPI_FRAME_ERR_EN adds frame_err and a read-data timeout.
module spi_slave_frontend
  import shared_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MOSI,
  input  logic                 SS_n,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0] FRAME_CNT = 4'(FRAME_BITS);

  spi_state_e            state_q;
  logic [3:0]            bit_cnt_q;
  logic [FRAME_BITS-2:0] shift_q;
  logic [FRAME_BITS-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rd_addr_seen_q;
  logic                  tx_wait_q;
`ifdef SPI_FRAME_ERR_EN
  localparam logic [3:0] TMO_LAST = 4'(TX_TIMEOUT - 1);
  logic [3:0]            tmo_q;
  logic                  frame_err_q;
`endif

  logic ser_load, ser_bit, ser_busy, ser_done;

  // tx_valid only counts inside the post-strobe wait of a read-data frame
  assign ser_load = (state_q == ST_READ_DATA) && tx_wait_q && !SS_n && tx_valid && !ser_busy;

  spi_tx_serializer u_tx_ser (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (SS_n),
    .load_i  (ser_load),
    .data_i  (tx_data),
    .bit_o   (ser_bit),
    .busy_o  (ser_busy),
    .done_o  (ser_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_wait_q      <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      tmo_q          <= '0;
      frame_err_q    <= 1'b0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err_q <= 1'b0;
`endif
      if (SS_n) begin
`ifdef SPI_FRAME_ERR_EN
        if ((bit_cnt_q != '0 && bit_cnt_q < FRAME_CNT) || ser_busy)
          frame_err_q <= 1'b1;
`endif
        state_q   <= ST_IDLE;
        bit_cnt_q <= '0;
        tx_wait_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_CHK_CMD;
          ST_CHK_CMD: begin
            shift_q   <= {shift_q[FRAME_BITS-3:0], MOSI};
            bit_cnt_q <= 4'd1;
            if (MOSI == CMD_WR_ADDR[1])
              state_q <= ST_WRITE;
            else if (rd_addr_seen_q)
              state_q <= ST_READ_DATA;
            else
              state_q <= ST_READ_ADD;
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            // bits beyond the frame length are dropped until SS_n rises
            if (bit_cnt_q < FRAME_CNT) begin
              shift_q   <= {shift_q[FRAME_BITS-3:0], MOSI};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
                rx_data_q  <= {shift_q, MOSI};
                rx_valid_q <= 1'b1;
                if (state_q == ST_READ_ADD)
                  rd_addr_seen_q <= 1'b1;
                if (state_q == ST_READ_DATA) begin
                  tx_wait_q <= 1'b1;
`ifdef SPI_FRAME_ERR_EN
                  tmo_q     <= '0;
`endif
                end
              end
            end
            if (tx_wait_q) begin
              if (ser_load) begin
                tx_wait_q <= 1'b0;
              end
`ifdef SPI_FRAME_ERR_EN
              else if (tmo_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                tx_wait_q   <= 1'b0;
              end else begin
                tmo_q <= tmo_q + 4'd1;
              end
`endif
            end
            if (ser_done)
              rd_addr_seen_q <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign MISO     = ser_bit;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb/tb_spi_slave_frontend.sv - scoreboard bench for spi_slave_frontend
module tb_spi_slave_frontend;

  logic       clk, rst, MOSI, SS_n, tx_valid, MISO, rx_valid;
  logic [7:0] tx_data;
  logic [9:0] rx_data;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave_frontend dut (
    .clk      (clk),
    .rst      (rst),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  typedef struct {
    int         cyc;
    logic [9:0] v;
  } exp_t;

  exp_t rxq[$];
  exp_t misoq[$];
  exp_t errq[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every output is compared on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_bit;
    if (cyc >= 2) begin
      if (rxq.size() > 0 && rxq[0].cyc < cyc) begin
        e = rxq.pop_front();
        n_vec++; n_miss++;
        $display("FAIL rx_strobe_missing: no strobe at cyc %0d, expected rx_data=%h", e.cyc, e.v);
      end
      if (rx_valid) begin
        n_vec++;
        if (rxq.size() == 0) begin
          n_miss++;
          $display("FAIL rx_strobe_unexpected: cyc=%0d rx_data=%h, expected no strobe", cyc, rx_data);
        end else begin
          e = rxq.pop_front();
          if (e.cyc != cyc || rx_data !== e.v) begin
            n_miss++;
            $display("FAIL rx_strobe: got rx_data=%h at cyc %0d, expected %h at cyc %0d", rx_data, cyc, e.v, e.cyc);
          end
        end
      end
      exp_bit = 1'b0;
      if (misoq.size() > 0 && misoq[0].cyc == cyc) begin
        e = misoq.pop_front();
        exp_bit = e.v[0];
      end
      n_vec++;
      if (MISO !== exp_bit) begin
        n_miss++;
        $display("FAIL miso: cyc=%0d got %b expected %b", cyc, MISO, exp_bit);
      end
`ifdef SPI_FRAME_ERR_EN
      exp_bit = 1'b0;
      if (errq.size() > 0 && errq[0].cyc == cyc) begin
        e = errq.pop_front();
        exp_bit = 1'b1;
      end
      n_vec++;
      if (frame_err !== exp_bit) begin
        n_miss++;
        $display("FAIL frame_err: cyc=%0d got %b expected %b", cyc, frame_err, exp_bit);
      end
`endif
    end
  end

  task automatic push_rx(input int c, input logic [9:0] v);
    exp_t e;
    e.cyc = c; e.v = v;
    rxq.push_back(e);
  endtask

  task automatic push_err(input int c);
    exp_t e;
    e.cyc = c; e.v = 10'd1;
    errq.push_back(e);
  endtask

  // Drops SS_n, then shifts n bits; bits past the tenth alternate 0/1.
  task automatic shift_bits(input logic [9:0] w, input int n, input int tv_at);
    logic b;
    SS_n = 1'b0; MOSI = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      b = i[0];
      if (i < 10) b = w[4'(9 - i)];
      MOSI     = b;
      tx_valid = (i == tv_at);
      tx_data  = 8'hFF;
      if (i == 9) push_rx(cyc + 1, w);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_data  = 8'h00;
  endtask

  task automatic end_frame(input bit exp_err);
    SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0;
    if (exp_err) push_err(cyc + 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Answers a read-data frame; nb < 8 aborts the shift after nb bits.
  task automatic serve_read(input logic [7:0] d, input int nb);
    exp_t e;
    tx_valid = 1'b1; tx_data = d;
    for (int j = 0; j < nb; j++) begin
      e.cyc = cyc + 1 + j;
      e.v   = {9'd0, d[3'(7 - j)]};
      misoq.push_back(e);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'h00;
    if (nb < 8) begin
      repeat (nb - 1) @(posedge clk);
      #1;
      end_frame(1'b1);
    end else begin
      repeat (10) @(posedge clk);
      #1;
      end_frame(1'b0);
    end
  endtask

  task automatic check_direct(input string name, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic pulse_tx(input logic [7:0] d);
    tx_valid = 1'b1; tx_data = d;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_data = 8'h00;
  endtask

  initial begin
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_direct("reset_rx_data", rx_data, 10'h000);
    check_direct("reset_rx_valid", {9'd0, rx_valid}, 10'd0);
    check_direct("reset_miso", {9'd0, MISO}, 10'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    shift_bits(10'h0A5, 10, -1);
    end_frame(1'b0);
    check_direct("rx_data_hold", rx_data, 10'h0A5);

    shift_bits(10'h155, 13, -1);
    end_frame(1'b0);

    shift_bits(10'h203, 10, -1);
    end_frame(1'b0);
    shift_bits(10'h3AA, 10, 4);
    serve_read(8'hC3, 8);

    shift_bits(10'h0F3, 5, -1);
    end_frame(1'b1);
    shift_bits(10'h1F0, 10, -1);
    end_frame(1'b0);

    shift_bits(10'h2F0, 10, -1);
    end_frame(1'b0);
    shift_bits(10'h3C0, 10, -1);
    serve_read(8'hA5, 3);
    shift_bits(10'h3FF, 10, -1);
    serve_read(8'h5A, 8);

    shift_bits(10'h201, 10, -1);
    end_frame(1'b0);
    shift_bits(10'h3FF, 6, -1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    check_direct("midframe_reset_rx_data", rx_data, 10'h000);
    check_direct("midframe_reset_rx_valid", {9'd0, rx_valid}, 10'd0);
    check_direct("midframe_reset_miso", {9'd0, MISO}, 10'd0);
    @(posedge clk); #1;

    shift_bits(10'h3C7, 10, -1);
    pulse_tx(8'hFF);
    end_frame(1'b0);
    shift_bits(10'h300, 10, -1);
    serve_read(8'h81, 8);

`ifdef SPI_FRAME_ERR_EN
    shift_bits(10'h2AA, 10, -1);
    end_frame(1'b0);
    shift_bits(10'h3AB, 10, -1);
    push_err(cyc + 16);
    repeat (20) @(posedge clk);
    #1;
    pulse_tx(8'hFF);
    end_frame(1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (rxq.size() != 0 || misoq.size() != 0
`ifdef SPI_FRAME_ERR_EN
        || errq.size() != 0
`endif
       ) begin
      n_miss++;
      $display("FAIL leftover_expectations: rx=%0d miso=%0d err=%0d, expected all 0",
               rxq.size(), misoq.size(), errq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
